mspeckey_dec_iter: RTL
======================

Name: mspeckey_dec_iter

Overview:
Round-iterative Speck128/128 decryption engine. It is the sequential inverse of the team's combinational Speck-family encryption datapath and recovers plaintext blocks from ciphertext produced by that path. The master key arrives with each request. Round keys are expanded on chip into a 32-entry register file and cached across requests that use the same key. Requests and results use valid/ready handshakes on both sides.

Parameters:
ROUNDS, 32, number of rounds (legal range 1..32); must match the encryption side.
ALPHA, 8, x-word rotation amount.
BETA, 3, y-word rotation amount.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  engine can accept a request.
key_i  input  128  master key; [127:64] = l0, [63:0] = k0.
state_i  input  128  ciphertext; [127:64] = x, [63:0] = y.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
state_o  output  128  plaintext, same x/y packing as state_i.

Behaviour:
- Reset values: in_ready = 1, out_valid = 0, state_o = 0. On reset, state returns to IDLE and the key cache is invalidated (key_vld = 0).
- FSM states: IDLE, EXPAND, DECRYPT, DONE. in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- IDLE: a request is accepted on an edge where in_valid = 1. On accept, capture x and y from state_i.
  - Hit (key_vld = 1 and key_i equals the cached key): go to DECRYPT with round index r = ROUNDS-1.
  - Miss: store key_i, set rk[0] = k0 and l = l0, set i = 0, go to EXPAND. If ROUNDS = 1, go directly to DECRYPT.
- EXPAND: one round key per cycle, all arithmetic mod 2^64.
  - l' = (rk[i] + ROR(l, ALPHA)) ^ i
  - rk[i+1] = ROL(rk[i], BETA) ^ l'
  - Runs for ROUNDS-1 cycles. When i = ROUNDS-2, set key_vld = 1 and go to DECRYPT with r = ROUNDS-1.
- DECRYPT: one inverse round per cycle.
  - y' = ROR(y ^ x, BETA)
  - x' = ROL((x ^ rk[r]) - y', ALPHA), subtraction mod 2^64
  - r decrements each cycle. After the r = 0 round, go to DONE with state_o = {x', y'}.
- DONE: state_o holds stable while out_valid = 1. On out_valid & out_ready, go to IDLE. New requests are never accepted in the same cycle as a result handshake.
- Latency from the accept edge to out_valid = 1:
  - miss: 2*ROUNDS-1 cycles (63 at default).
  - hit: ROUNDS cycles (32 at default).
- in_valid and key_i are ignored outside IDLE. Any key change during a run takes effect only at the next accept.
- key_vld is cleared when a miss starts and set only when expansion completes. A reset during EXPAND therefore leaves no partially valid cache.
- Reset in any state aborts the operation: out_valid drops on the next edge and no partial result is emitted.

Test Plan:
- Known answer: key 0f0e0d0c0b0a0908_0706050403020100, state_i a65d985179783265_7860fedf5c570d18, out_ready = 1 -> state_o = 6c61766975716520_7469206564616d20 exactly 63 cycles after accept; in_ready = 0 throughout.
- Cache hit: repeat the same key and ciphertext immediately -> same plaintext after 32 cycles. Then send a key with one bit flipped -> 63-cycle latency and a different result.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> state_o stable, in_ready = 0, in_valid ignored. Assert out_ready -> in_ready = 1 on the next cycle.
- Reset mid-EXPAND at cycle 20, then the same request as the known-answer test -> a full 63-cycle miss path, correct plaintext.
- Reset mid-DECRYPT on a hit run -> out_valid never rises for the aborted request; the next request takes the miss path.
- Random round trip: 200 random key/plaintext pairs, encrypted by the team's encryption model, decrypted here -> the original plaintext is recovered every time, with out_ready toggled randomly.

Source files
------------

// File: rtl/mspeckey_dec_iter.sv
// Round-iterative Speck128/128 decryption engine with an on-chip expanded-key cache.
// One key-schedule step or one inverse round per clock; valid/ready on both sides.
module mspeckey_dec_iter #(
    parameter int ROUNDS = 32,
    parameter int ALPHA  = 8,
    parameter int BETA   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_i,
    input  logic [127:0] state_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_o
);

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

    localparam logic [4:0] R_LAST = 5'(ROUNDS - 1);
    localparam logic [4:0] I_LAST = 5'(ROUNDS - 2);

    function automatic logic [63:0] ror_a(input logic [63:0] v);
        return {v[ALPHA-1:0], v[63:ALPHA]};
    endfunction

    function automatic logic [63:0] rol_a(input logic [63:0] v);
        return {v[63-ALPHA:0], v[63:64-ALPHA]};
    endfunction

    function automatic logic [63:0] ror_b(input logic [63:0] v);
        return {v[BETA-1:0], v[63:BETA]};
    endfunction

    function automatic logic [63:0] rol_b(input logic [63:0] v);
        return {v[63-BETA:0], v[63:64-BETA]};
    endfunction

    state_t         state;
    state_t         state_next;
    logic [63:0]    rk [0:31];
    logic [63:0]    x;
    logic [63:0]    y;
    logic [63:0]    l;
    logic [127:0]   key_q;
    logic           key_vld;
    logic [4:0]     idx;
    logic           hit;
    logic [63:0]    l_next;
    logic [63:0]    rk_next;
    logic [63:0]    x_dec;
    logic [63:0]    y_dec;

    // Key-schedule step and inverse round, both indexed by the shared round counter.
    always_comb begin
        hit     = key_vld && (key_i == key_q);
        l_next  = (rk[idx] + ror_a(l)) ^ {59'd0, idx};
        rk_next = rol_b(rk[idx]) ^ l_next;
        y_dec   = ror_b(y ^ x);
        x_dec   = rol_a((x ^ rk[idx]) - y_dec);
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (hit || (ROUNDS == 1)) state_next = DECRYPT;
                    else                      state_next = EXPAND;
                end else begin
                    state_next = IDLE;
                end
            end
            EXPAND: begin
                if (idx == I_LAST) state_next = DECRYPT;
                else               state_next = EXPAND;
            end
            DECRYPT: begin
                if (idx == 5'd0) state_next = DONE;
                else             state_next = DECRYPT;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
                else           state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Cipher state, key cache tag and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_vld <= 1'b0;
            key_q   <= 128'd0;
            x       <= 64'd0;
            y       <= 64'd0;
            l       <= 64'd0;
            idx     <= 5'd0;
            state_o <= 128'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x <= state_i[127:64];
                        y <= state_i[63:0];
                        if (hit) begin
                            idx <= R_LAST;
                        end else begin
                            // Cache stays invalid until the whole schedule exists.
                            key_q   <= key_i;
                            l       <= key_i[127:64];
                            key_vld <= (ROUNDS == 1);
                            idx     <= (ROUNDS == 1) ? R_LAST : 5'd0;
                        end
                    end
                end
                EXPAND: begin
                    l <= l_next;
                    if (idx == I_LAST) begin
                        key_vld <= 1'b1;
                        idx     <= R_LAST;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                DECRYPT: begin
                    x   <= x_dec;
                    y   <= y_dec;
                    idx <= idx - 5'd1;
                    if (idx == 5'd0) state_o <= {x_dec, y_dec};
                end
                default: ;
            endcase
        end
    end

    // Round-key file; contents are only trusted while key_vld is set.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && !hit) rk[0] <= key_i[63:0];
        else if (state == EXPAND)              rk[idx + 5'd1] <= rk_next;
    end

endmodule
